array_sum_reader: RTL and testbench
===================================

# array_sum_reader

Read-side initiator for the 2-port block RAM, which has a 2-cycle registered read latency. On `start` it streams `len` consecutive words out of the RAM read port, beginning at `base`, and accumulates them into a wrapping sum. It then reports the result with a one-cycle `done` pulse. It sits between the sum-of-array control logic and the RAM read port; the RAM write port remains owned by the loader.

## Interface
- `ADDR_W`, 10: RAM address width; the RAM depth is 2^ADDR_W words.
- `DATA_W`, 32: RAM word width and accumulator width.
- `RD_LAT`, 2: RAM read latency in cycles, from `mem_read_en` to valid `mem_read_val`; the RAM fixes it at 2.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `base`  in  ADDR_W  first word address; sampled with `start`.
- `len`  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `sum` is final in this cycle.
- `sum`  out  DATA_W  accumulated result; held until the next accepted `start`.
- `mem_read_en`  out  1  to the RAM `read_en`.
- `mem_read_addr`  out  ADDR_W  to the RAM `read_addr`.
- `mem_read_val`  in  DATA_W  from the RAM `read_val`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Transitions:
  - IDLE to ISSUE on `start` with `len`≠0.
  - IDLE to DONE on `start` with `len`=0.
  - ISSUE to DRAIN after the last read is issued.
  - DRAIN to DONE once all RD_LAT in-flight reads have been accumulated.
  - DONE to IDLE unconditionally.
- On an accepted `start`:
  - latch `base` and `len`;
  - clear `sum` to 0;
  - clear the issue counter `i`.
- ISSUE:
  - drive `mem_read_en`=1 and `mem_read_addr`=(base+i) mod 2^ADDR_W each cycle;
  - increment `i`;
  - exactly `len` reads are issued, back-to-back with no bubbles.
- In-flight tracking: a valid shift register RD_LAT deep tracks outstanding reads. When its tail bit is set, add `mem_read_val` to `sum`.
- Arithmetic: `sum` wraps modulo 2^DATA_W; there is no overflow flag.
- Addresses wrap past 2^ADDR_W−1 to 0.
- `len`=2^ADDR_W reads every word exactly once.
- `start` is ignored while `busy`=1; no queuing.
- `mem_read_en`=0 in every state except ISSUE.
- `mem_read_addr` is don't-care when `mem_read_en`=0 and is driven 0 in that case.
- Reset mid-operation:
  - FSM returns to IDLE and the valid pipe clears;
  - RAM data still in flight is discarded and is never added;
  - no `done` pulse is produced for the aborted run.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `mem_read_en`=0, `mem_read_addr`=0.
- Cycle numbering: cycle 0 is the cycle in which `start` is high in IDLE.
- Read issue: reads are issued in cycles 1..len.
- Read return: a read issued in cycle k returns `mem_read_val` valid in cycle k+2 and is added at the end of that cycle.
- Completion: `done`=1 and `busy`=1 in cycle len+3. `sum` equals the full total from cycle len+3 onward.
- Return to IDLE: `busy`=0 from cycle len+4. A new `start` is accepted in cycle len+4 at the earliest.
- `len`=0: `done` pulses in cycle 1 with `sum`=0, and no reads are issued.
- Throughput: one word per cycle. Total latency is len+3 cycles from `start` to `done`.

## Test plan
- Basic sum:
  - Stimulus: preload ram[0..7]=1..8; start with base=0, len=8.
  - Response: `mem_read_en` high for exactly cycles 1..8 with addresses 0..7; `done` in cycle 11; `sum`=36.
- Address wrap:
  - Stimulus: ram[1022]=5, ram[1023]=6, ram[0]=7; base=1022, len=3.
  - Response: addresses 1022, 1023, 0 in order; `sum`=18; `done` in cycle 6.
- Zero length and full length:
  - Stimulus 1: len=0. Response: `done` in cycle 1, `sum`=0, `mem_read_en` never asserted.
  - Stimulus 2: len=1024 with ram[i]=i. Response: `sum`=523776; `done` in cycle 1027.
- Sum overflow:
  - Stimulus: ram[0]=ram[1]=32'hFFFF_FFFF, ram[2]=2; base=0, len=3.
  - Response: `sum`=0.
- Start while busy and back-to-back runs:
  - Stimulus: a second `start` pulse mid-ISSUE; then a new start in cycle len+4.
  - Response: the mid-ISSUE `start` has no effect on addresses or `sum`. The second run is accepted, and `sum` clears to 0 before accumulating.
- Reset mid-run:
  - Stimulus: assert `rst` asynchronously in cycle 4 of a len=8 run, then release it.
  - Response: all outputs at reset values immediately; no `done` pulse. A subsequent len=2 run yields the correct sum, with no stale data added.

Source files
------------

// File: rtl/array_sum_reader.sv
// Read-side initiator: streams `len` words from a fixed-latency block RAM starting
// at `base` and accumulates them into a wrapping sum, then pulses `done`.
module array_sum_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_val
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] vpipe_rest;
  logic              accept;
  logic              last_issue;

  assign accept     = (state == IDLE) && start;
  assign last_issue = (cnt == len_q - 1'b1);
  // Everything still in flight except the read being accumulated this cycle.
  assign vpipe_rest = vpipe << 1;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nx      = state;
    busy          = (state != IDLE);
    done          = (state == DONE);
    mem_read_en   = 1'b0;
    mem_read_addr = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = (len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        mem_read_en   = 1'b1;
        mem_read_addr = base_q + cnt[ADDR_W-1:0];
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (vpipe_rest == '0) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the valid pipe is reset so RAM data in flight at reset is never summed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      vpipe  <= '0;
      sum    <= '0;
    end else begin
      state <= state_nx;
      vpipe <= vpipe_rest | RD_LAT'(mem_read_en);
      if (accept) begin
        base_q <= base;
        len_q  <= len;
        cnt    <= '0;
        sum    <= '0;
      end else begin
        if (state == ISSUE) cnt <= cnt + 1'b1;
        if (vpipe[RD_LAT-1]) sum <= sum + mem_read_val;
      end
    end
  end

endmodule

// File: tb/tb_array_sum_reader.sv
// Directed and randomized bench for array_sum_reader with a behavioural RAM
// and a sum/timing reference computed directly from the memory image.
module tb_array_sum_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;
  logic        busy, done, mem_read_en;
  logic [31:0] sum, mem_read_val;
  logic [9:0]  mem_read_addr;

  logic [31:0] mem [1024];
  logic [31:0] d1, d2;

  int total = 0;
  int passed = 0;
  int fails = 0;

  array_sum_reader dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .sum(sum),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_val(mem_read_val)
  );

  always #5 clk = ~clk;

  // Two registered stages model the RAM's fixed read latency.
  always @(posedge clk) begin
    d1 <= mem[mem_read_addr];
    d2 <= d1;
  end
  assign mem_read_val = d2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: start in cycle 0, follow the run until done (bounded), compare
  // address stream, done cycle and final sum with the reference.
  task automatic run(input logic [9:0] b, input logic [10:0] n, input bit poke, input bit post);
    logic [31:0] exp_sum;
    int exp_done, c, issued, done_c;
    exp_sum = 0;
    for (int j = 0; j < int'(n); j++) exp_sum += mem[(int'(b) + j) % 1024];
    exp_done = (n == 0) ? 1 : int'(n) + 3;
    @(negedge clk);
    start = 1'b1; base = b; len = n;
    c = 0; issued = 0; done_c = -1;
    while (done_c < 0 && c < int'(n) + 10) begin
      @(negedge clk);
      c++;
      start = poke && (c == 3);
      base  = 10'($urandom);
      len   = 11'($urandom_range(0, 1024));
      if (mem_read_en) begin
        check("rd_addr", 64'(mem_read_addr), 64'((int'(b) + issued) % 1024));
        issued++;
        check("rd_cycle", 64'(c), 64'(issued));
      end
      if (c == 1) check("sum_clear", 64'(sum), 64'd0);
      if (done) begin
        done_c = c;
        check("busy_at_done", 64'(busy), 64'd1);
        check("sum", 64'(sum), 64'(exp_sum));
      end
    end
    start = 1'b0;
    check("done_cycle", 64'(done_c), 64'(exp_done));
    check("read_count", 64'(issued), 64'(n));
    if (post) begin
      @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
      check("done_pulse", 64'(done), 64'd0);
      check("sum_held", 64'(sum), 64'(exp_sum));
    end
  endtask

  initial begin
    int done_seen, en_seen;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_en", 64'(mem_read_en), 64'd0);
    check("rst_addr", 64'(mem_read_addr), 64'd0);
    rst = 1'b0;

    // Basic sum: ram[0..7] = 1..8
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    run(10'd0, 11'd8, 1'b0, 1'b1);
    check("basic_const", 64'(sum), 64'd36);

    // Address wrap
    mem[1022] = 32'd5; mem[1023] = 32'd6; mem[0] = 32'd7;
    run(10'd1022, 11'd3, 1'b0, 1'b1);
    check("wrap_const", 64'(sum), 64'd18);

    // Zero length
    run(10'd77, 11'd0, 1'b0, 1'b1);

    // Sum overflow
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'hFFFF_FFFF; mem[2] = 32'd2;
    run(10'd0, 11'd3, 1'b0, 1'b1);
    check("ovf_const", 64'(sum), 64'd0);

    // Full length
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    run(10'd0, 11'd1024, 1'b0, 1'b1);
    check("full_const", 64'(sum), 64'd523776);

    // Start while busy, then a back-to-back start in cycle len+4
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run(10'd500, 11'd9, 1'b1, 1'b0);
    run(10'd3, 11'd4, 1'b0, 1'b1);

    // Randomized runs
    for (int k = 0; k < 8; k++)
      run(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 40)), k[0], k[1]);

    // Reset mid-run in cycle 4 of a len=8 run
    @(negedge clk);
    start = 1'b1; base = 10'd10; len = 11'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_sum", 64'(sum), 64'd0);
    check("arst_en", 64'(mem_read_en), 64'd0);
    check("arst_addr", 64'(mem_read_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0; en_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (mem_read_en) en_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);
    check("arst_no_reads", 64'(en_seen), 64'd0);
    run(10'd200, 11'd2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
